// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: ALU control codes, divider width and FSM state encoding
package div_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = $clog2(DATA_W);
  localparam int ALU_W = 5;
  localparam logic [ALU_W-1:0] ADD_CONTROL = 5'b00010;
  localparam logic [ALU_W-1:0] DIV_CONTROL = 5'b01100;
  localparam logic [ALU_W-1:0] DIVU_CONTROL = 5'b01101;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: execute-stage divide request and HI/LO result bus
interface div_ctrl_if;
  import div_ctrl_pkg::*;
  logic start, annul, stall, result_valid;
  logic [ALU_W-1:0] alucontrol;
  logic [DATA_W-1:0] a, b, hi, lo;
  modport master(output start, alucontrol, a, b, annul, input stall, result_valid, hi, lo);
  modport slave(input start, alucontrol, a, b, annul, output stall, result_valid, hi, lo);
endinterface

// File: rtl/div_ctrl_step.sv
// div_step: one restoring-division iteration (shift, trial subtract, select)
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_n,
  output logic [DATA_W-1:0] quo_n
);
  logic [DATA_W:0] sh, trial;
  always_comb begin
    sh = {rem, quo[DATA_W-1]};
    trial = sh - {1'b0, dvs};
    rem_n = trial[DATA_W] ? sh[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_n = {quo[DATA_W-2:0], ~trial[DATA_W]};
  end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller stalling the pipeline until HI/LO are ready
module div_ctrl
  import div_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  div_ctrl_if.slave bus
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] rem, quo, dvs, rem_n, quo_n;
  logic q_neg, r_neg, sgn, go;
  assign sgn = bus.alucontrol == DIV_CONTROL;
  assign go = bus.start & ~bus.annul & ~rst & (sgn | bus.alucontrol == DIVU_CONTROL) & state == IDLE;
  assign bus.stall = go | state == BUSY;
  assign bus.result_valid = state == DONE & ~bus.annul;
  div_step u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_n(rem_n), .quo_n(quo_n));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else if (bus.annul) state <= IDLE;
    else case (state)
      IDLE: if (go) begin
        cnt <= '0;
        rem <= '0;
        quo <= neg_if(sgn & bus.a[DATA_W-1], bus.a);
        dvs <= neg_if(sgn & bus.b[DATA_W-1], bus.b);
        q_neg <= sgn & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
        r_neg <= sgn & bus.a[DATA_W-1];
        // divide by zero skips iteration and reports all-ones quotient, raw dividend
        if (bus.b == '0) begin
          state <= DONE;
          bus.hi <= bus.a;
          bus.lo <= '1;
        end else state <= BUSY;
      end
      BUSY: begin
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          state <= DONE;
          bus.hi <= neg_if(r_neg, rem_n);
          bus.lo <= neg_if(q_neg, quo_n);
        end
      end
      default: state <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl against an arithmetic model
module tb_div_ctrl;
  import div_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  div_ctrl_if bus();
  div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] elo, output logic [31:0] ehi);
    if (y == 0) begin
      elo = '1;
      ehi = x;
    end else if (op == DIV_CONTROL) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        elo = 32'h8000_0000;
        ehi = 0;
      end else begin
        elo = $signed(x) / $signed(y);
        ehi = $signed(x) % $signed(y);
      end
    end else begin
      elo = x / y;
      ehi = x % y;
    end
  endfunction
  // called mid-cycle (just after a negedge); that cycle is cycle 0 of the launch
  task automatic do_div(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] elo, ehi;
    int lat, nstall;
    bit got;
    model(op, x, y, elo, ehi);
    lat = (y == 0) ? 1 : 33;
    bus.start = 1'b1;
    bus.alucontrol = op;
    bus.a = x;
    bus.b = y;
    #1;
    nstall = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.result_valid) begin
        got = 1;
        check("rv_cycle", 64'(k), 64'(lat));
        check("rv_stall", {63'b0, bus.stall}, 64'd0);
        check("lo", {32'b0, bus.lo}, {32'b0, elo});
        check("hi", {32'b0, bus.hi}, {32'b0, ehi});
        bus.start = 1'b0;
      end else if (bus.stall) nstall++;
    end
    check("done_in_budget", {63'b0, got}, 64'd1);
    bus.start = 1'b0;
    check("stall_cycles", 64'(nstall), 64'(lat));
    @(negedge clk);
    check("idle_after", {62'b0, bus.stall, bus.result_valid}, 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.alucontrol = ADD_CONTROL;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    check("rst_outs", {bus.stall, bus.result_valid, bus.hi, bus.lo}, 66'd0);
    rst = 1'b0;
    @(negedge clk);
    do_div(DIVU_CONTROL, 100, 7);
    @(negedge clk);
    do_div(DIV_CONTROL, 32'hFFFF_FFF9, 2);
    @(negedge clk);
    do_div(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    do_div(DIVU_CONTROL, 5, 0);
    // annul in BUSY at cycle 10, relaunch in cycle 11
    @(negedge clk);
    bus.start = 1'b1;
    bus.alucontrol = DIV_CONTROL;
    bus.a = 1000;
    bus.b = 3;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    #1;
    check("annul_busy_rv", {63'b0, bus.result_valid}, 64'd0);
    @(negedge clk);
    bus.annul = 1'b0;
    check("after_annul", {62'b0, bus.stall, bus.result_valid}, 64'd0);
    do_div(DIVU_CONTROL, 9, 4);
    // annul in DONE suppresses result_valid
    @(negedge clk);
    bus.start = 1'b1;
    bus.alucontrol = DIVU_CONTROL;
    bus.a = 8;
    bus.b = 0;
    @(negedge clk);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    #1;
    check("annul_done_rv", {63'b0, bus.result_valid}, 64'd0);
    @(negedge clk);
    bus.annul = 1'b0;
    #1;
    check("annul_done_idle", {62'b0, bus.stall, bus.result_valid}, 64'd0);
    // annul with start in IDLE
    bus.start = 1'b1;
    bus.alucontrol = DIV_CONTROL;
    bus.a = 77;
    bus.b = 5;
    bus.annul = 1'b1;
    #1;
    check("annul_start_stall", {63'b0, bus.stall}, 64'd0);
    @(negedge clk);
    check("annul_start_nolaunch", {63'b0, bus.stall}, 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    // reset mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.alucontrol = DIVU_CONTROL;
    bus.a = 1234567;
    bus.b = 89;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid", {bus.stall, bus.result_valid, bus.hi, bus.lo}, 66'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b1;
    bus.alucontrol = ADD_CONTROL;
    #1;
    check("add_no_stall", {63'b0, bus.stall}, 64'd0);
    @(negedge clk);
    check("add_idle", {62'b0, bus.stall, bus.result_valid}, 64'd0);
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: y = '1;
        2: y = $urandom_range(1, 16);
        default: y = $urandom;
      endcase
      @(negedge clk);
      do_div($urandom_range(0, 1) ? DIV_CONTROL : DIVU_CONTROL, x, y);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide controller for the execute stage. It accepts DIV/DIVU operations decoded by the ALU decoder and runs a 32-iteration restoring division over the rs/rt operands. While it runs, it stalls the pipeline. It then presents quotient (LO) and remainder (HI) for one cycle so the HI/LO register file can capture them.

## Interface
- DATA_W, 32, operand/result width; iteration count equals DATA_W.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  execute-stage instruction valid.
- alucontrol  in  5  decoded ALU control; only DIV_CONTROL / DIVU_CONTROL launch an operation.
- a  in  DATA_W  dividend (rs).
- b  in  DATA_W  divisor (rt).
- annul  in  1  flush of the execute stage (exception/branch squash).
- stall  out  1  hold the pipeline front end and execute stage.
- result_valid  out  1  one-cycle pulse; hi/lo valid this cycle.
- hi  out  DATA_W  remainder.
- lo  out  DATA_W  quotient.

## Operation
- Launch condition: `go = start & ~annul & (alucontrol==DIV_CONTROL | alucontrol==DIVU_CONTROL) & state==IDLE`.
- States:
  - IDLE → BUSY on go with b≠0.
  - IDLE → DONE on go with b==0.
  - BUSY → DONE when iteration counter reaches DATA_W-1.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on annul.
- On launch, latch:
  - signed flag (DIV_CONTROL);
  - |a| and |b| (magnitude only when signed);
  - quotient sign q_neg = a[MSB]^b[MSB] (signed only);
  - remainder sign r_neg = a[MSB] (signed only).
- BUSY, one step per cycle: shift {rem, quo} left by 1; trial = rem − |b| on DATA_W+1 bits.
  - If trial is non-negative: rem = trial and quo[0] = 1.
  - Otherwise: quo[0] = 0.
- Entering DONE:
  - lo = q_neg ? −quo : quo.
  - hi = r_neg ? −rem : rem.
  - Two's-complement negate, truncated to DATA_W bits.
- Divide by zero: lo = all ones, hi = a (raw operand). No trap is raised.
- Overflow case (signed most-negative / −1): lo = 0x80000000, hi = 0. This falls out of truncation; no special path.
- hi/lo hold their last value outside DONE. Consumers sample only on result_valid.
- Boundary behaviour:
  - start in BUSY or DONE is ignored. In DONE it is the same instruction still in execute and must not relaunch.
  - start with a non-divide alucontrol is ignored.
  - annul together with start in IDLE: no launch, stall = 0.
  - annul in DONE: result_valid forced to 0 that cycle.
  - annul in BUSY: abort and drop the partial result.

## Timing
- All outputs reset to 0; state resets to IDLE; counter resets to 0. Reset takes effect immediately, including mid-operation.
- stall (combinational) = go | state==BUSY. It is low in IDLE (without go) and in DONE.
- Normal divide, launch in cycle 0:
  - stall is high in cycles 0–32.
  - BUSY occupies cycles 1–32.
  - result_valid is high in cycle 33, with stall low.
  - The pipeline advances at the end of cycle 33.
- Divide by zero, launch in cycle 0:
  - stall is high in cycle 0 only.
  - result_valid is high in cycle 1.
- Back-to-back divides: the earliest next launch is cycle 34, i.e. IDLE after DONE.
- annul in cycle k during BUSY: stall = 0 and state = IDLE from cycle k+1. A new launch is accepted in cycle k+1.

## Structure
- DIV_CONTROL, DIVU_CONTROL and the FSM state encodings (IDLE/BUSY/DONE, 2 bits) go in the shared defines header next to the existing ALU control codes.
- One sub-module, div_step: combinational single-iteration shift/trial-subtract/select on {rem, quo, |b|}.
- Instantiated once in div_ctrl.

## Test plan
- DIVU a=100, b=7 → stall high for 33 cycles; result_valid in cycle 33 with lo=14, hi=2.
- DIV a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 33.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000; no hang.
- DIVU a=5, b=0 → stall high in cycle 0 only; result_valid in cycle 1 with lo=0xFFFFFFFF, hi=5.
- DIV launched, annul at cycle 10:
  - stall=0 from cycle 11; no result_valid pulse.
  - DIVU 9/4 launched in cycle 11 → result_valid in cycle 44 with lo=2, hi=1.
- rst asserted at cycle 20 of a divide → stall, result_valid, hi and lo are 0 immediately. After release, start with alucontrol=ADD_CONTROL → no stall, no result_valid.
